// File: rtl/jump_pkg.sv
// Shared definitions for the jump game: state width and state codes.
// Man_squeeze, the renderer and the game sequencer all use this package.
package jump_pkg;

    localparam int unsigned STATE_W = 3;

    // Code 2 is unused. It must decode as illegal and return to S_INIT.
    typedef enum logic [STATE_W-1:0] {
        S_INIT   = 3'd0,
        S_WAIT   = 3'd1,
        S_PRESS  = 3'd3,
        S_JUMP   = 3'd4,
        S_CHECK  = 3'd5,
        S_SCROLL = 3'd6,
        S_OVER   = 3'd7
    } state_e;

endpackage

// File: rtl/tick_counter.sv
// Enabled up-counter with synchronous clear and a terminal-count flag at MAX.
// With SAT set, the counter holds at MAX; otherwise it wraps at its width.
module tick_counter #(
    parameter int unsigned W   = 8,
    parameter int unsigned MAX = 255,
    parameter bit          SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_c  = (cnt_q == W'(MAX));
    assign count = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !(SAT && tc_c)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jump_game_ctrl.sv
// Jump game sequencer: turns button hold time into jump power, times the jump and scroll
// animations on frame ticks, requests a landing check, and keeps the score.
module jump_game_ctrl
    import jump_pkg::*;
#(
    parameter int unsigned POWER_W       = 8,
    parameter int unsigned MAX_POWER     = 200,
    parameter int unsigned JF_W          = 5,
    parameter int unsigned JUMP_FRAMES   = 32,
    parameter int unsigned SCROLL_FRAMES = 16,
    parameter int unsigned SCORE_W       = 10
) (
    input  logic               clk_machine,
    input  logic               rst_machine,
    input  logic               tick,
    input  logic               btn,
    input  logic               land_valid,
    input  logic               land_hit,
    output logic [2:0]         o_state,
    output logic [POWER_W-1:0] o_power,
    output logic [JF_W-1:0]    o_jump_frame,
    output logic               o_check_req,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_game_over
);

    localparam int unsigned SC_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    state_e             state_q, state_d;
    logic               btn_prev_q, btn_prev_d;
    logic               check_req_q, check_req_d;
    logic               game_over_q, game_over_d;
    logic [SCORE_W-1:0] score_q, score_d;

    logic               press_c, release_c;
    logic               pwr_clr, pwr_en, pwr_tc_c;
    logic               jf_clr, jf_en, jf_tc_c;
    logic               sc_clr, sc_en, sc_tc_c;
    logic [SC_W-1:0]    scroll_cnt;

    assign press_c   = btn & ~btn_prev_q;
    assign release_c = ~btn & btn_prev_q;

    // State register and registered outputs; btn_prev resets high to mask a held button.
    always_ff @(posedge clk_machine) begin
        if (rst_machine) begin
            state_q     <= S_INIT;
            btn_prev_q  <= 1'b1;
            check_req_q <= 1'b0;
            game_over_q <= 1'b0;
            score_q     <= '0;
        end else begin
            state_q     <= state_d;
            btn_prev_q  <= btn_prev_d;
            check_req_q <= check_req_d;
            game_over_q <= game_over_d;
            score_q     <= score_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   if (press_c)   state_d = S_WAIT;
            S_WAIT:   if (press_c)   state_d = S_PRESS;
            S_PRESS:  if (release_c) state_d = S_JUMP;
            S_JUMP:   if (tick && jf_tc_c) state_d = S_CHECK;
            S_CHECK:  if (land_valid) state_d = land_hit ? S_SCROLL : S_OVER;
            S_SCROLL: if (tick && sc_tc_c) state_d = S_WAIT;
            S_OVER:   if (press_c)   state_d = S_INIT;
            default:  state_d = S_INIT;
        endcase
    end

    // Counter controls and next values of the registered outputs.
    always_comb begin
        btn_prev_d  = btn;
        pwr_clr     = (state_d == S_WAIT);
        pwr_en      = (state_q == S_PRESS) && tick && !release_c && !pwr_tc_c;
        jf_clr      = (state_d == S_WAIT);
        jf_en       = (state_q == S_JUMP) && tick;
        sc_clr      = (state_q != S_SCROLL);
        sc_en       = (state_q == S_SCROLL) && tick;
        check_req_d = (state_q == S_JUMP) && (state_d == S_CHECK);
        game_over_d = (state_d == S_OVER);
        score_d     = score_q;
        if (state_d == S_INIT) begin
            score_d = '0;
        end else if ((state_q == S_CHECK) && land_valid && land_hit
                     && (score_q != {SCORE_W{1'b1}})) begin
            score_d = score_q + SCORE_W'(1);
        end
    end

    tick_counter #(.W(POWER_W), .MAX(MAX_POWER), .SAT(1'b0)) u_power (
        .clk   (clk_machine),
        .rst   (rst_machine),
        .clr   (pwr_clr),
        .en    (pwr_en),
        .count (o_power),
        .tc_c  (pwr_tc_c)
    );

    // Frame index holds at its last value on the tick that ends the jump.
    tick_counter #(.W(JF_W), .MAX(JUMP_FRAMES - 1), .SAT(1'b1)) u_jump_frame (
        .clk   (clk_machine),
        .rst   (rst_machine),
        .clr   (jf_clr),
        .en    (jf_en),
        .count (o_jump_frame),
        .tc_c  (jf_tc_c)
    );

    tick_counter #(.W(SC_W), .MAX(SCROLL_FRAMES - 1), .SAT(1'b0)) u_scroll (
        .clk   (clk_machine),
        .rst   (rst_machine),
        .clr   (sc_clr),
        .en    (sc_en),
        .count (scroll_cnt),
        .tc_c  (sc_tc_c)
    );

    assign o_state     = state_q;
    assign o_check_req = check_req_q;
    assign o_score     = score_q;
    assign o_game_over = game_over_q;

endmodule

// File: tb/tb_jump_game_ctrl.sv
// Bench for jump_game_ctrl: directed game scenarios plus randomized play, checked every cycle
// against a rule-level model of the game.
module tb_jump_game_ctrl;

    localparam int POWER_W       = 8;
    localparam int MAX_POWER     = 200;
    localparam int JF_W          = 5;
    localparam int JUMP_FRAMES   = 32;
    localparam int SCROLL_FRAMES = 16;
    localparam int SCORE_W       = 10;

    logic               clk = 1'b0;
    logic               rst, tick, btn, lv, lh;
    logic [2:0]         o_state;
    logic [POWER_W-1:0] o_power;
    logic [JF_W-1:0]    o_jump_frame;
    logic               o_check_req;
    logic [SCORE_W-1:0] o_score;
    logic               o_game_over;

    jump_game_ctrl #(
        .POWER_W(POWER_W), .MAX_POWER(MAX_POWER), .JF_W(JF_W),
        .JUMP_FRAMES(JUMP_FRAMES), .SCROLL_FRAMES(SCROLL_FRAMES), .SCORE_W(SCORE_W)
    ) dut (
        .clk_machine  (clk),
        .rst_machine  (rst),
        .tick         (tick),
        .btn          (btn),
        .land_valid   (lv),
        .land_hit     (lh),
        .o_state      (o_state),
        .o_power      (o_power),
        .o_jump_frame (o_jump_frame),
        .o_check_req  (o_check_req),
        .o_score      (o_score),
        .o_game_over  (o_game_over)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Rule-level game model: state code, power, frames, ticks seen while scrolling, score.
    int m_state = 0, m_power = 0, m_frame = 0, m_scroll = 0, m_score = 0;
    int m_req = 0, m_over = 0;
    bit m_btn_prev = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit pr, rl;
        int nxt;
        if (rst) begin
            m_state = 0; m_power = 0; m_frame = 0; m_scroll = 0; m_score = 0;
            m_req = 0; m_over = 0; m_btn_prev = 1'b1;
        end else begin
            pr = btn && !m_btn_prev;
            rl = !btn && m_btn_prev;
            nxt = m_state;
            m_req = 0;
            case (m_state)
                0: if (pr) nxt = 1;
                1: if (pr) nxt = 3;
                3: if (rl) nxt = 4;
                   else if (tick) m_power = (m_power < MAX_POWER) ? m_power + 1 : MAX_POWER;
                4: if (tick) begin
                       if (m_frame == JUMP_FRAMES - 1) begin nxt = 5; m_req = 1; end
                       else m_frame++;
                   end
                5: if (lv) begin
                       if (lh) begin
                           nxt = 6; m_scroll = 0;
                           if (m_score < (1 << SCORE_W) - 1) m_score++;
                       end else nxt = 7;
                   end
                6: if (tick) begin
                       m_scroll++;
                       if (m_scroll == SCROLL_FRAMES) nxt = 1;
                   end
                7: if (pr) nxt = 0;
                default: nxt = 0;
            endcase
            if (nxt == 1) begin m_power = 0; m_frame = 0; end
            if (nxt == 0) m_score = 0;
            m_state = nxt;
            m_over = (nxt == 7) ? 1 : 0;
            m_btn_prev = btn;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",      32'(o_state),      m_state);
            chk("power",      32'(o_power),      m_power);
            chk("jump_frame", 32'(o_jump_frame), m_frame);
            chk("check_req",  32'(o_check_req),  m_req);
            chk("score",      32'(o_score),      m_score);
            chk("game_over",  32'(o_game_over),  m_over);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic tk();
        tick = 1'b1; cyc();
        tick = 1'b0; cyc();
    endtask

    initial begin
        int pulses;
        rst = 1'b1; btn = 1'b1; tick = 1'b0; lv = 1'b0; lh = 1'b0;
        cyc(); cyc();
        chk_en = 1'b1;
        chk("rst_state", 32'(o_state), 0);
        chk("rst_score", 32'(o_score), 0);

        // Button held through reset must not count as a press.
        rst = 1'b0;
        repeat (3) cyc();
        chk("held_btn_state", 32'(o_state), 0);
        btn = 1'b0; cyc();
        btn = 1'b1; cyc();
        chk("init_to_wait", 32'(o_state), 1);
        btn = 1'b0; cyc();
        btn = 1'b1; cyc();
        chk("wait_to_press", 32'(o_state), 3);

        // Ten ticks of charge, then tick and release together: release wins.
        repeat (10) tk();
        chk("power_10", 32'(o_power), 10);
        tick = 1'b1; btn = 1'b0; cyc();
        tick = 1'b0;
        chk("release_to_jump", 32'(o_state), 4);
        chk("tick_release_power", 32'(o_power), 10);

        // Landing result outside S_CHECK is ignored.
        lv = 1'b1; lh = 1'b1; cyc();
        lv = 1'b0; lh = 1'b0;
        chk("lv_ignored", 32'(o_state), 4);

        pulses = 0;
        repeat (JUMP_FRAMES) begin
            tick = 1'b1; cyc(); pulses += int'(o_check_req);
            tick = 1'b0; cyc(); pulses += int'(o_check_req);
        end
        repeat (3) begin cyc(); pulses += int'(o_check_req); end
        chk("jump_to_check", 32'(o_state), 5);
        chk("check_req_once", 32'(pulses), 1);

        lv = 1'b1; lh = 1'b1; cyc();
        lv = 1'b0; lh = 1'b0;
        chk("hit_scroll", 32'(o_state), 6);
        chk("hit_score", 32'(o_score), 1);
        repeat (SCROLL_FRAMES - 1) tk();
        chk("scroll_15", 32'(o_state), 6);
        chk("scroll_power_hold", 32'(o_power), 10);
        tk();
        chk("scroll_to_wait", 32'(o_state), 1);
        chk("wait_power_clr", 32'(o_power), 0);

        // Power saturation, then a miss ends the game.
        btn = 1'b1; cyc();
        repeat (250) tk();
        chk("power_sat", 32'(o_power), MAX_POWER);
        btn = 1'b0; cyc();
        repeat (JUMP_FRAMES) tk();
        lv = 1'b1; lh = 1'b0; cyc();
        lv = 1'b0;
        chk("miss_over", 32'(o_state), 7);
        chk("over_flag", 32'(o_game_over), 1);
        repeat (3) cyc();
        chk("over_score_hold", 32'(o_score), 1);
        btn = 1'b1; cyc();
        chk("over_to_init", 32'(o_state), 0);
        chk("init_score_clr", 32'(o_score), 0);

        // Reset in the middle of a jump.
        btn = 1'b0; cyc(); btn = 1'b1; cyc();
        btn = 1'b0; cyc(); btn = 1'b1; cyc();
        repeat (3) tk();
        btn = 1'b0; cyc();
        repeat (17) tk();
        chk("frame_17", 32'(o_jump_frame), 17);
        rst = 1'b1; tick = 1'b1; cyc();
        rst = 1'b0; tick = 1'b0;
        chk("midrst_state", 32'(o_state), 0);
        chk("midrst_power", 32'(o_power), 0);
        chk("midrst_frame", 32'(o_jump_frame), 0);
        chk("midrst_req", 32'(o_check_req), 0);
        chk("midrst_over", 32'(o_game_over), 0);
        cyc();
        chk("midrst_req_after", 32'(o_check_req), 0);

        // Randomized play.
        for (int i = 0; i < 20000; i++) begin
            tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) btn = ~btn;
            lv  = ($urandom_range(0, 9) == 0);
            lh  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 2999) == 0);
            cyc();
        end
        rst = 1'b0; tick = 1'b0; lv = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
